// File: rtl/gcd_sched.sv
// gcd_sched: round-robin front end that shares one start/done GCD engine
// among NUM_REQ requesters. It takes one operand pair at a time. A pair that
// contains a zero is answered directly and never reaches the engine, because
// a subtractive engine never finishes on a zero operand. Results return on a
// single tagged response channel. A watchdog aborts an engine that stalls.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot, IDLE only)
//   req_a/req_b           flattened operands, requester i at [i*NUM_WIDTH +: NUM_WIDTH]
//   rsp_valid/rsp_ready   response handshake (held until accepted)
//   rsp_id/rsp_data/rsp_err  response tag, GCD result, watchdog timeout flag
//   eng_start/eng_abort   one-cycle pulses to the engine
//   eng_a/eng_b           engine operands, stable from start to done/abort
//   eng_done/eng_result   engine completion pulse and result
module gcd_sched #(
   parameter int NUM_WIDTH  = 16,
   parameter int NUM_REQ    = 4,
   parameter int MAX_CYCLES = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*NUM_WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*NUM_WIDTH-1:0]   req_b,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
   output logic [NUM_WIDTH-1:0]           rsp_data,
   output logic                           rsp_err,
   output logic                           eng_start,
   output logic                           eng_abort,
   output logic [NUM_WIDTH-1:0]           eng_a,
   output logic [NUM_WIDTH-1:0]           eng_b,
   input  logic                           eng_done,
   input  logic [NUM_WIDTH-1:0]           eng_result
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_CYCLES);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       rr_ptr;
   logic [CNT_W-1:0]      cnt;
   logic                  win_found;
   logic [ID_W-1:0]       win_id;
   logic [NUM_WIDTH-1:0]  win_a, win_b;
   logic                  win_zero;

   // Round-robin pick: first valid requester after the last winner, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         automatic int idx = (int'(rr_ptr) + 1 + i) % NUM_REQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
   end

   assign win_a    = req_a[int'(win_id)*NUM_WIDTH +: NUM_WIDTH];
   assign win_b    = req_b[int'(win_id)*NUM_WIDTH +: NUM_WIDTH];
   assign win_zero = (win_a == '0) || (win_b == '0);

   always_comb begin
      req_ready = '0;
      if (state == IDLE && win_found)
         req_ready[win_id] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      eng_start = 1'b0;
      eng_abort = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            if (win_found)
               state_nxt = win_zero ? RESP : ISSUE;
         end
         ISSUE: begin
            eng_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            // A completion in the limit cycle beats the watchdog.
            if (eng_done)
               state_nxt = RESP;
            else if (cnt == LIMIT) begin
               eng_abort = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= ID_W'(NUM_REQ - 1);
         cnt      <= '0;
         eng_a    <= '0;
         eng_b    <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (win_found) begin
                  rr_ptr <= win_id;
                  rsp_id <= win_id;
                  if (win_zero) begin
                     // gcd(x,0)=x and gcd(0,0)=0, so the OR is the answer.
                     rsp_data <= win_a | win_b;
                     rsp_err  <= 1'b0;
                  end else begin
                     eng_a <= win_a;
                     eng_b <= win_b;
                  end
               end
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (eng_done) begin
                  rsp_data <= eng_result;
                  rsp_err  <= 1'b0;
               end else if (cnt == LIMIT) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_sched.sv
module tb_gcd_sched;

   localparam int W = 16;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_a = '0;
   logic [N*W-1:0]  req_b = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [1:0]      rsp_id;
   logic [W-1:0]    rsp_data;
   logic            rsp_err;
   logic            eng_start, eng_abort;
   logic [W-1:0]    eng_a, eng_b;
   logic            eng_done = 1'b0;
   logic [W-1:0]    eng_result = '0;

   gcd_sched #(.NUM_WIDTH(W), .NUM_REQ(N), .MAX_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .eng_start(eng_start), .eng_abort(eng_abort),
      .eng_a(eng_a), .eng_b(eng_b),
      .eng_done(eng_done), .eng_result(eng_result)
   );

   always #5 clk = ~clk;

   // Engine model: done pulses m_delay cycles after the start cycle.
   int           m_delay = 5;
   bit           m_hang  = 1'b0;
   logic [W-1:0] m_res   = 16'd6;
   bit           inject  = 1'b0;
   int           m_cnt   = 0;

   always @(posedge clk) begin
      #2;
      eng_done = 1'b0;
      if (rst)
         m_cnt = 0;
      else if (eng_start)
         m_cnt = m_hang ? 0 : m_delay;
      else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            eng_done   = 1'b1;
            eng_result = m_res;
         end
      end
      if (inject)
         eng_done = 1'b1;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Per-transaction observations.
   int           lat, starts, aborts, start_at, abort_at;
   logic [W-1:0] st_a, st_b;

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i]    = 1'b1;
   endtask

   // Called at a negedge in IDLE; returns at the first negedge with rsp_valid.
   task automatic run_txn(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      set_req(i, a, b);
      #1;
      chk("accept_ready", 32'(req_ready), 32'(1 << i));
      lat = 0; starts = 0; aborts = 0; start_at = -1; abort_at = -1;
      do begin
         @(negedge clk);
         if (lat == 0) req_valid[i] = 1'b0;
         lat++;
         if (eng_start) begin
            starts++; start_at = lat; st_a = eng_a; st_b = eng_b;
         end
         if (eng_abort) begin
            aborts++; abort_at = lat;
         end
      end while (!rsp_valid && lat < 60);
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   int bad;
   logic [W-1:0] d0;
   logic [1:0]   id0;
   logic         e0;
   int g [10];
   int ng;
   int exp_g [10] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};

   initial begin
      #200000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "simulation time limit");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_eng_start", 32'(eng_start), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_eng_a", 32'(eng_a), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single request through the engine.
      m_delay = 5; m_res = 16'd6;
      run_txn(0, 16'd48, 16'd18);
      chk("t1_latency", 32'(lat), 7);
      chk("t1_starts", 32'(starts), 1);
      chk("t1_start_at", 32'(start_at), 1);
      chk("t1_eng_a", 32'(st_a), 48);
      chk("t1_eng_b", 32'(st_b), 18);
      chk("t1_id", 32'(rsp_id), 0);
      chk("t1_data", 32'(rsp_data), 6);
      chk("t1_err", 32'(rsp_err), 0);
      finish_rsp();

      // Zero-operand bypass.
      run_txn(3, 16'd0, 16'd35);
      chk("z1_latency", 32'(lat), 1);
      chk("z1_starts", 32'(starts), 0);
      chk("z1_id", 32'(rsp_id), 3);
      chk("z1_data", 32'(rsp_data), 35);
      chk("z1_err", 32'(rsp_err), 0);
      finish_rsp();
      run_txn(1, 16'd21, 16'd0);
      chk("z2_latency", 32'(lat), 1);
      chk("z2_starts", 32'(starts), 0);
      chk("z2_data", 32'(rsp_data), 21);
      finish_rsp();
      run_txn(2, 16'd0, 16'd0);
      chk("z3_latency", 32'(lat), 1);
      chk("z3_starts", 32'(starts), 0);
      chk("z3_id", 32'(rsp_id), 2);
      chk("z3_data", 32'(rsp_data), 0);
      finish_rsp();

      // Done arriving in the watchdog limit cycle wins.
      m_delay = 8; m_res = 16'd3;
      run_txn(0, 16'd9, 16'd6);
      chk("lim_latency", 32'(lat), 10);
      chk("lim_aborts", 32'(aborts), 0);
      chk("lim_err", 32'(rsp_err), 0);
      chk("lim_data", 32'(rsp_data), 3);
      finish_rsp();

      // Watchdog with a hung engine.
      m_hang = 1'b1;
      run_txn(1, 16'd10, 16'd4);
      chk("wd_latency", 32'(lat), 10);
      chk("wd_aborts", 32'(aborts), 1);
      chk("wd_abort_gap", 32'(abort_at - start_at), 8);
      chk("wd_err", 32'(rsp_err), 1);
      chk("wd_data", 32'(rsp_data), 0);
      chk("wd_id", 32'(rsp_id), 1);
      finish_rsp();
      m_hang = 1'b0; m_delay = 2; m_res = 16'd2;
      run_txn(2, 16'd10, 16'd4);
      chk("wd_next_latency", 32'(lat), 4);
      chk("wd_next_aborts", 32'(aborts), 0);
      chk("wd_next_err", 32'(rsp_err), 0);
      chk("wd_next_data", 32'(rsp_data), 2);
      finish_rsp();

      // Backpressure with requester 1 waiting.
      m_delay = 2; m_res = 16'd5;
      run_txn(0, 16'd15, 16'd10);
      set_req(1, 16'd8, 16'd12);
      d0 = rsp_data; id0 = rsp_id; e0 = rsp_err;
      chk("bp_data", 32'(d0), 5);
      chk("bp_id", 32'(id0), 0);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== id0 || rsp_err !== e0) bad++;
         if (req_ready !== '0) bad++;
         @(negedge clk);
      end
      chk("bp_stable", 32'(bad), 0);
      finish_rsp();
      #1;
      chk("bp_next_grant", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid[1] = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_next_valid", 32'(rsp_valid), 1);
      chk("bp_next_id", 32'(rsp_id), 1);
      finish_rsp();

      // Reset in the middle of WAIT.
      m_hang = 1'b1;
      set_req(3, 16'd7, 16'd5);
      @(negedge clk);
      req_valid[3] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_rsp_valid", 32'(rsp_valid), 0);
      chk("mr_eng_start", 32'(eng_start), 0);
      chk("mr_eng_abort", 32'(eng_abort), 0);
      chk("mr_eng_a", 32'(eng_a), 0);
      chk("mr_eng_b", 32'(eng_b), 0);
      chk("mr_rsp_id", 32'(rsp_id), 0);
      chk("mr_rsp_data", 32'(rsp_data), 0);
      chk("mr_rsp_err", 32'(rsp_err), 0);
      chk("mr_req_ready", 32'(req_ready), 0);
      rst = 1'b0;
      inject = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (rsp_valid || eng_start || eng_abort) bad++;
         @(negedge clk);
      end
      chk("mr_stray_done", 32'(bad), 0);

      // Round robin with all requesters asserting, then requester 2 drops.
      m_hang = 1'b0; m_delay = 1; m_res = 16'd2;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 16'd6, 16'd4);
      #1;
      chk("rr_first_grant", 32'(req_ready), 32'h1);
      for (int i = 0; i < 10; i++) g[i] = -1;
      ng = 0;
      for (int c = 0; c < 300 && ng < 10; c++) begin
         if (req_ready != '0) begin
            for (int k = 0; k < N; k++)
               if (req_ready[k]) g[ng] = k;
            ng++;
            if (ng == 6) req_valid[2] = 1'b0;
         end
         @(negedge clk);
         #1;
      end
      for (int i = 0; i < 10; i++)
         chk($sformatf("rr_grant%0d", i), 32'(g[i]), 32'(exp_g[i]));

      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/gcd_sched.md
Name: gcd_sched

Overview:
Round-robin scheduler that shares one GCD engine among NUM_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake and bypasses zero operands, which a subtractive engine never terminates on. It issues a one-cycle start to the engine, guards the engine with a watchdog, and returns tagged results on a single response channel. It sits between client logic and a GCD engine that has a start/done interface.

Parameters:
NUM_WIDTH, 16, operand/result width
NUM_REQ, 4, number of requesters (>=2)
MAX_CYCLES, 1024, watchdog limit on engine busy cycles (>=2)
ID_W, $clog2(NUM_REQ), requester-id width (derived localparam)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  one-hot accept; combinational, asserted only in IDLE
req_a  in  NUM_REQ*NUM_WIDTH  flattened A operands; requester i uses bits [i*NUM_WIDTH +: NUM_WIDTH]
req_b  in  NUM_REQ*NUM_WIDTH  flattened B operands, same slicing
rsp_valid  out  1  response valid; held until accepted
rsp_ready  in  1  response accept
rsp_id  out  ID_W  index of the requester the response belongs to
rsp_data  out  NUM_WIDTH  GCD result
rsp_err  out  1  watchdog timeout flag; rsp_data=0 when set
eng_start  out  1  one-cycle start pulse to the engine
eng_abort  out  1  one-cycle engine abort/reset pulse
eng_a  out  NUM_WIDTH  engine operand A; held stable from start until done or abort
eng_b  out  NUM_WIDTH  engine operand B; held stable, same rule as eng_a
eng_done  in  1  engine completion pulse
eng_result  in  NUM_WIDTH  engine result, valid while eng_done=1

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
  - Watchdog counter=0.
  - All outputs 0, including eng_a, eng_b, rsp_id and rsp_data.
  - Reset mid-operation abandons the transaction with no response. Engine reset is handled by the shared rst.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle; this cycle is the transfer.
  - On the transfer: capture the winner's a, b and id; rr_ptr<=winner.
  - If a==0 or b==0, go to RESP with rsp_data=a|b (gcd(x,0)=x, gcd(0,0)=0) and rsp_err=0. The engine is not touched.
  - Otherwise, go to ISSUE.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- ISSUE: eng_start=1 for exactly this cycle, eng_a/eng_b driven from the captured operands, counter cleared; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - If eng_done=1: rsp_data<=eng_result, rsp_err<=0, go to RESP.
  - Else if counter==MAX_CYCLES-1: eng_abort=1 for this cycle, rsp_data<=0, rsp_err<=1, go to RESP.
  - If eng_done arrives in the same cycle the limit is reached, eng_done wins and there is no abort.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are stable until rsp_ready=1.
  - On rsp_ready=1: go to IDLE.
  - No new request is accepted in the handoff cycle. The earliest next accept is the cycle after the response transfer.
- eng_done outside WAIT is ignored.
- req_ready is never asserted outside IDLE.
- Operand changes on non-granted requesters have no effect.
- Latency, from the accept cycle T:
  - eng_start at T+1.
  - With engine done at T+1+k (k>=1), rsp_valid rises at T+2+k.
  - Zero bypass: rsp_valid at T+1.
- Fairness: each continuously asserting requester is granted at least once every NUM_REQ grants.

Test Plan:
- Single request: requester 0 sends a=48, b=18; engine model returns 6 after 5 cycles -> one eng_start pulse at T+1, eng_a=48, eng_b=18; response rsp_id=0, rsp_data=6, rsp_err=0 at T+7.
- Round robin: all 4 requesters hold valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1.
  - Then requester 2 drops valid -> order continues 3,0,1,3 with no lockout.
- Zero bypass:
  - (0,35) -> rsp_data=35; (21,0) -> 21; (0,0) -> 0.
  - eng_start is never asserted; rsp_valid at T+1.
- Watchdog: MAX_CYCLES=8, engine never raises eng_done -> eng_abort pulses exactly once, 8 cycles after eng_start; response rsp_err=1, rsp_data=0; the next request proceeds normally.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP with requester 1 valid -> response fields stable, req_ready stays 0.
  - After release, requester 1 is granted the cycle after the response transfer.
- Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0, no response emitted, and a stray eng_done afterwards is ignored.
  - The next request is granted to requester 0 first.
